// File: rtl/wb_history_fwd_if.sv
// wb_history_fwd_if: groups write-back capture inputs, lookup indices and forwarding results.
// Latency: none (wires only).
// Backpressure: none; stall/flush are level inputs to the history block.
// Ports: master = pipeline side (drives stall/flush/wb_*/rs*), slave = history block.
interface wb_history_fwd_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            stall;
    logic            flush;
    logic            wb_MemRd;
    logic            wb_RegWr;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;

    logic            extra_MemRd;
    logic            extra_RegWr;
    logic [AW-1:0]   extra_rd;
    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
    logic            ld_hit1;
    logic            ld_hit2;
    logic [2:0]      age1;
    logic [2:0]      age2;
    logic [3:0]      occ;

    modport master (
        output stall, flush, wb_MemRd, wb_RegWr, wb_rd, wb_data, rs1, rs2,
        input  extra_MemRd, extra_RegWr, extra_rd, hit1, hit2, fwd_data1, fwd_data2,
               ld_hit1, ld_hit2, age1, age2, occ
    );

    modport slave (
        input  stall, flush, wb_MemRd, wb_RegWr, wb_rd, wb_data, rs1, rs2,
        output extra_MemRd, extra_RegWr, extra_rd, hit1, hit2, fwd_data1, fwd_data2,
               ld_hit1, ld_hit2, age1, age2, occ
    );
endinterface

// File: rtl/wb_history_fwd.sv
// wb_history_fwd: shift-register history of the last DEPTH retired register writes, with rs1/rs2 forwarding lookup.
// Latency: a write-back is visible in entry 0 / extra_* one cycle later; lookup is combinational on registered entries.
// Backpressure: stall freezes history and occ; flush zeroes every entry and wins over stall and capture.
// Ports: clk, rst (async active-low), bus (wb_history_fwd_if.slave).
module wb_history_fwd #(
    parameter int DEPTH = 3,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    wb_history_fwd_if.slave bus
);
    typedef struct packed {
        logic            vld;
        logic            mem_rd;
        logic            reg_wr;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] dat;
    } entry_t;

    entry_t     hist     [DEPTH];
    entry_t     hist_nxt [DEPTH];
    entry_t     wb_ent;
    logic [3:0] occ_q;
    logic [3:0] occ_nxt;

    // Writes to x0 keep their control fields (extra_* still shows them) but can never forward.
    always_comb begin
        wb_ent.vld    = bus.wb_RegWr && (bus.wb_rd != '0);
        wb_ent.mem_rd = bus.wb_MemRd;
        wb_ent.reg_wr = bus.wb_RegWr;
        wb_ent.rd     = bus.wb_rd;
        wb_ent.dat    = bus.wb_data;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            hist_nxt[k] = hist[k];
        end
        if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                hist_nxt[k] = '0;
            end
        end else if (!bus.stall) begin
            hist_nxt[0] = wb_ent;
            for (int k = 1; k < DEPTH; k++) begin
                hist_nxt[k] = hist[k-1];
            end
        end
        // occ is registered from the next-state valid bits so it moves on the same edge as the entries.
        occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt = occ_nxt + {3'b000, hist_nxt[k].vld};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= hist_nxt[k];
            end
            occ_q <= occ_nxt;
        end
    end

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        bus.hit1      = 1'b0;
        bus.fwd_data1 = '0;
        bus.ld_hit1   = 1'b0;
        bus.age1      = '0;
        bus.hit2      = 1'b0;
        bus.fwd_data2 = '0;
        bus.ld_hit2   = 1'b0;
        bus.age2      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist[k].vld && (hist[k].rd == bus.rs1) && (bus.rs1 != '0)) begin
                bus.hit1      = 1'b1;
                bus.fwd_data1 = hist[k].dat;
                bus.ld_hit1   = hist[k].mem_rd;
                bus.age1      = 3'(k);
            end
            if (hist[k].vld && (hist[k].rd == bus.rs2) && (bus.rs2 != '0)) begin
                bus.hit2      = 1'b1;
                bus.fwd_data2 = hist[k].dat;
                bus.ld_hit2   = hist[k].mem_rd;
                bus.age2      = 3'(k);
            end
        end
    end

    assign bus.extra_MemRd = hist[0].mem_rd;
    assign bus.extra_RegWr = hist[0].reg_wr;
    assign bus.extra_rd    = hist[0].rd;
    assign bus.occ         = occ_q;
endmodule

// File: tb/tb_wb_history_fwd.sv
// tb_wb_history_fwd: directed and random checks of wb_history_fwd at DEPTH=3 and DEPTH=1 against a queue model.
// Latency: model updated at each rising edge, outputs compared 1 time unit later.
// Backpressure: stall/flush/reset driven directly by the stimulus.
module tb_wb_history_fwd;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        bit            vld;
        bit            mr;
        bit            rw;
        bit [AW-1:0]   rd;
        bit [XLEN-1:0] data;
    } ment_t;

    typedef struct packed {
        logic            hit;
        logic            ld;
        logic [2:0]      age;
        logic [XLEN-1:0] data;
    } res_t;

    logic            clk;
    logic            rst;
    logic            stall, flush, wb_MemRd, wb_RegWr;
    logic [AW-1:0]   wb_rd, rs1, rs2;
    logic [XLEN-1:0] wb_data;

    int vectors     = 0;
    int miscompares = 0;

    ment_t q3[$];
    ment_t q1[$];

    wb_history_fwd_if #(.XLEN(XLEN), .AW(AW)) bus3 ();
    wb_history_fwd_if #(.XLEN(XLEN), .AW(AW)) bus1 ();

    assign bus3.stall = stall;    assign bus1.stall = stall;
    assign bus3.flush = flush;    assign bus1.flush = flush;
    assign bus3.wb_MemRd = wb_MemRd;  assign bus1.wb_MemRd = wb_MemRd;
    assign bus3.wb_RegWr = wb_RegWr;  assign bus1.wb_RegWr = wb_RegWr;
    assign bus3.wb_rd = wb_rd;    assign bus1.wb_rd = wb_rd;
    assign bus3.wb_data = wb_data;    assign bus1.wb_data = wb_data;
    assign bus3.rs1 = rs1;        assign bus1.rs1 = rs1;
    assign bus3.rs2 = rs2;        assign bus1.rs2 = rs2;

    wb_history_fwd #(.DEPTH(3), .XLEN(XLEN), .AW(AW)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    wb_history_fwd #(.DEPTH(1), .XLEN(XLEN), .AW(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ment_t ent(input int inst, input int i);
        if (inst == 0) return q3[i];
        return q1[i];
    endfunction

    function automatic int dep(input int inst);
        return (inst == 0) ? q3.size() : q1.size();
    endfunction

    // Youngest matching entry wins: first hit when walking from entry 0.
    function automatic res_t find(input int inst, input logic [AW-1:0] rs);
        res_t  r;
        ment_t e;
        r = '0;
        for (int i = 0; i < dep(inst); i++) begin
            e = ent(inst, i);
            if (!r.hit && e.vld && e.rd == rs && rs != 0) begin
                r.hit  = 1'b1;
                r.ld   = e.mr;
                r.age  = 3'(i);
                r.data = e.data;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        foreach (q3[i]) q3[i] = '0;
        foreach (q1[i]) q1[i] = '0;
    endtask

    task automatic model_edge();
        ment_t n;
        n.vld  = wb_RegWr && (wb_rd != 0);
        n.mr   = wb_MemRd;
        n.rw   = wb_RegWr;
        n.rd   = wb_rd;
        n.data = wb_data;
        if (!rst || flush) begin
            model_clear();
        end else if (!stall) begin
            q3.push_front(n); void'(q3.pop_back());
            q1.push_front(n); void'(q1.pop_back());
        end
    endtask

    task automatic check_dut(input string p, input int inst,
                             input logic mr, input logic rw, input logic [AW-1:0] rd,
                             input logic h1, input logic l1, input logic [XLEN-1:0] f1, input logic [2:0] a1,
                             input logic h2, input logic l2, input logic [XLEN-1:0] f2, input logic [2:0] a2,
                             input logic [3:0] oc);
        ment_t e0;
        res_t  r1, r2;
        int    n;
        e0 = ent(inst, 0);
        r1 = find(inst, rs1);
        r2 = find(inst, rs2);
        n = 0;
        for (int i = 0; i < dep(inst); i++) n += int'(ent(inst, i).vld);
        chk({p, "_extra_MemRd"}, mr, e0.mr);
        chk({p, "_extra_RegWr"}, rw, e0.rw);
        chk({p, "_extra_rd"}, rd, e0.rd);
        chk({p, "_hit1"}, h1, r1.hit);
        chk({p, "_ld_hit1"}, l1, r1.ld);
        chk({p, "_fwd_data1"}, f1, r1.data);
        chk({p, "_age1"}, a1, r1.age);
        chk({p, "_hit2"}, h2, r2.hit);
        chk({p, "_ld_hit2"}, l2, r2.ld);
        chk({p, "_fwd_data2"}, f2, r2.data);
        chk({p, "_age2"}, a2, r2.age);
        chk({p, "_occ"}, oc, 4'(n));
    endtask

    task automatic check_all();
        check_dut("d3", 0, bus3.extra_MemRd, bus3.extra_RegWr, bus3.extra_rd,
                  bus3.hit1, bus3.ld_hit1, bus3.fwd_data1, bus3.age1,
                  bus3.hit2, bus3.ld_hit2, bus3.fwd_data2, bus3.age2, bus3.occ);
        check_dut("d1", 1, bus1.extra_MemRd, bus1.extra_RegWr, bus1.extra_rd,
                  bus1.hit1, bus1.ld_hit1, bus1.fwd_data1, bus1.age1,
                  bus1.hit2, bus1.ld_hit2, bus1.fwd_data2, bus1.age2, bus1.occ);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_wb(input logic mr, input logic rw, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wb_MemRd = mr;
        wb_RegWr = rw;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) q3.push_back('0);
        q1.push_back('0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        rs1 = '0; rs2 = '0;
        set_wb(1'b1, 1'b1, 5'd4, 32'h1111);

        // Reset state, held across one edge while write-back inputs are active.
        #1;
        check_all();
        chk("rst_occ", bus3.occ, 4'd0);
        step();
        chk("rst_edge_extra_RegWr", bus3.extra_RegWr, 1'b0);
        #2 rst = 1'b1;

        // Aging out of a single write through three entries.
        set_wb(1'b0, 1'b1, 5'd5, 32'hAAAA);
        step();
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        rs1 = 5'd5;
        #1 check_all();
        chk("age_hit1", bus3.hit1, 1'b1);
        chk("age_fwd1", bus3.fwd_data1, 32'hAAAA);
        chk("age_age1", bus3.age1, 3'd2);
        chk("age_d1_hit1", bus1.hit1, 1'b0);
        step();
        chk("aged_out_hit1", bus3.hit1, 1'b0);
        chk("aged_out_occ", bus3.occ, 4'd0);

        // Two writes to the same register: youngest (a load) wins.
        set_wb(1'b0, 1'b1, 5'd7, 32'd1);
        step();
        set_wb(1'b1, 1'b1, 5'd7, 32'd2);
        rs2 = 5'd7;
        step();
        chk("yng_fwd2", bus3.fwd_data2, 32'd2);
        chk("yng_ld2", bus3.ld_hit2, 1'b1);
        chk("yng_age2", bus3.age2, 3'd0);

        // x0 write is stored but never valid.
        flush = 1'b1; step(); flush = 1'b0;
        set_wb(1'b0, 1'b1, 5'd0, 32'hFFFF);
        rs1 = 5'd0;
        step();
        chk("x0_hit1", bus3.hit1, 1'b0);
        chk("x0_occ", bus3.occ, 4'd0);
        chk("x0_extra_RegWr", bus3.extra_RegWr, 1'b1);
        chk("x0_extra_rd", bus3.extra_rd, 5'd0);

        // Stall holds history while wb inputs keep changing.
        flush = 1'b1; step(); flush = 1'b0;
        set_wb(1'b0, 1'b1, 5'd3, 32'd9);
        step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_wb(1'($urandom), 1'b1, 5'($urandom_range(1, 31)), $urandom);
            step();
        end
        rs1 = 5'd3;
        #1 check_all();
        chk("stall_age1", bus3.age1, 3'd0);
        chk("stall_occ", bus3.occ, 4'd1);
        chk("stall_fwd1", bus3.fwd_data1, 32'd9);
        stall = 1'b0;

        // Flush with stall and a valid write pending.
        set_wb(1'b1, 1'b1, 5'd1, 32'h10); step();
        set_wb(1'b0, 1'b1, 5'd2, 32'h20); step();
        set_wb(1'b1, 1'b1, 5'd4, 32'h40); step();
        chk("full_occ", bus3.occ, 4'd3);
        rs1 = 5'd1; rs2 = 5'd2;
        flush = 1'b1; stall = 1'b1;
        set_wb(1'b1, 1'b1, 5'd6, 32'h60);
        step();
        chk("flush_occ", bus3.occ, 4'd0);
        chk("flush_hit1", bus3.hit1, 1'b0);
        chk("flush_hit2", bus3.hit2, 1'b0);
        chk("flush_extra_MemRd", bus3.extra_MemRd, 1'b0);
        chk("flush_extra_RegWr", bus3.extra_RegWr, 1'b0);
        chk("flush_extra_rd", bus3.extra_rd, 5'd0);
        flush = 1'b0; stall = 1'b0;

        // Asynchronous reset between edges, then first capture after release.
        set_wb(1'b0, 1'b1, 5'd10, 32'hA0); step();
        set_wb(1'b1, 1'b1, 5'd11, 32'hB0); step();
        rs1 = 5'd10; rs2 = 5'd11;
        #1 chk("pre_rst_occ", bus3.occ, 4'd2);
        #1 rst = 1'b0;
        model_clear();
        #1 check_all();
        chk("async_occ", bus3.occ, 4'd0);
        chk("async_hit2", bus3.hit2, 1'b0);
        chk("async_extra_rd", bus3.extra_rd, 5'd0);
        #2 rst = 1'b1;
        set_wb(1'b0, 1'b1, 5'd12, 32'h1234);
        rs1 = 5'd12;
        step();
        chk("rel_extra_rd", bus3.extra_rd, 5'd12);
        chk("rel_occ", bus3.occ, 4'd1);
        chk("rel_age1", bus3.age1, 3'd0);

        // Random traffic on a small register range to provoke multiple matches.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            set_wb(1'($urandom), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
